// File: rtl/flag_controller_pkg.sv
// Shared types and constants for the status-flag controller and its saved-flag stack.
package flag_controller_pkg;

  localparam int STACK_DEPTH_DEF = 4;

  // Bit positions inside the flag_op request mask.
  localparam int OP_CSET   = 3;
  localparam int OP_CRESET = 2;
  localparam int OP_ZSET   = 1;
  localparam int OP_ZRESET = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_t;

  // Set requests win over reset requests on the same flag.
  function automatic logic [3:0] resolve_mask(input logic [3:0] op);
    logic [3:0] m;
    m = op;
    if (op[OP_CSET]) m[OP_CRESET] = 1'b0;
    if (op[OP_ZSET]) m[OP_ZRESET] = 1'b0;
    return m;
  endfunction

  // One-hot of the highest set bit, which is the next strobe to issue.
  function automatic logic [3:0] first_bit(input logic [3:0] m);
    logic [3:0] f;
    casez (m)
      4'b1???: f = 4'b1000;
      4'b01??: f = 4'b0100;
      4'b001?: f = 4'b0010;
      4'b0001: f = 4'b0001;
      default: f = 4'b0000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/flag_stack.sv
// Small synchronous LIFO of saved {C,Z} flag pairs; a simultaneous push and pop
// overwrites the top entry after it has been read.
module flag_stack
  import flag_controller_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] din,
  output logic [1:0] dout,
  output logic [2:0] depth,
  output logic       full,
  output logic       empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]    mem [DEPTH];
  logic [IW-1:0] top_idx;
  logic [IW-1:0] wr_idx;
  logic          do_pop;
  logic          do_push;

  assign empty   = (depth == 3'd0);
  assign full    = (depth == 3'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push onto a full stack still lands.
  assign do_push = push & (~full | do_pop);
  assign top_idx = IW'(depth - 3'd1);
  assign wr_idx  = do_pop ? top_idx : IW'(depth);
  assign dout    = empty ? 2'b00 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
    end else begin
      if (do_push) mem[wr_idx] <= din;
      if (do_push && !do_pop)      depth <= depth + 3'd1;
      else if (do_pop && !do_push) depth <= depth - 3'd1;
    end
  end

endmodule

// File: rtl/flag_controller.sv
// Arbitrates ALU updates, stack restores and set/reset flag requests into registered
// drive for the status register, sequencing multi-bit flag_op masks one strobe per cycle.
module flag_controller
  import flag_controller_pkg::*;
#(
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       ExternalReset,
  input  logic       alu_upd,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic [3:0] flag_op,
  input  logic       push,
  input  logic       pop,
  input  logic       sr_c,
  input  logic       sr_z,
  output logic       SRload,
  output logic       Cin,
  output logic       Zin,
  output logic       Cset,
  output logic       Creset,
  output logic       Zset,
  output logic       Zreset,
  output logic       busy,
  output logic [2:0] stack_depth,
  output logic       ovf_err,
  output logic       unf_err,
  output logic       drop_err
);

  state_t     state;
  logic [3:0] pend;
  logic [3:0] mask;
  logic [3:0] first;
  logic [3:0] seq_first;
  logic       has_op;
  logic       stk_pop;
  logic       pop_ok;
  logic [1:0] stk_dout;
  logic       stk_full;
  logic       stk_empty;

  assign has_op    = |flag_op;
  assign mask      = resolve_mask(flag_op);
  assign first     = first_bit(mask);
  assign seq_first = first_bit(pend);
  // Pops are requests and are discarded while busy; pushes are always served.
  assign stk_pop   = pop & ~busy;
  assign pop_ok    = stk_pop & ~stk_empty;

  flag_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .rst   (ExternalReset),
    .push  (push),
    .pop   (stk_pop),
    .din   ({sr_c, sr_z}),
    .dout  (stk_dout),
    .depth (stack_depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (ExternalReset) begin
      state    <= ST_IDLE;
      pend     <= '0;
      busy     <= 1'b0;
      SRload   <= 1'b0;
      Cin      <= 1'b0;
      Zin      <= 1'b0;
      {Cset, Creset, Zset, Zreset} <= 4'b0000;
      ovf_err  <= 1'b0;
      unf_err  <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      SRload <= 1'b0;
      Cin    <= 1'b0;
      Zin    <= 1'b0;
      {Cset, Creset, Zset, Zreset} <= 4'b0000;
      if (push && stk_full && !pop_ok) ovf_err <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (pop) begin
            if (stk_empty) unf_err <= 1'b1;
            else begin
              SRload     <= 1'b1;
              {Cin, Zin} <= stk_dout;
            end
            if (alu_upd || has_op) drop_err <= 1'b1;
          end else if (alu_upd) begin
            SRload <= 1'b1;
            Cin    <= alu_c;
            Zin    <= alu_z;
            if (has_op) drop_err <= 1'b1;
          end else if (has_op) begin
            {Cset, Creset, Zset, Zreset} <= first;
            pend <= mask & ~first;
            if ((mask & ~first) != 4'b0000) begin
              state <= ST_SEQ;
              busy  <= 1'b1;
            end
          end
        end
        ST_SEQ: begin
          if (alu_upd || pop || has_op) drop_err <= 1'b1;
          {Cset, Creset, Zset, Zreset} <= seq_first;
          pend <= pend & ~seq_first;
          // Drop busy together with the last strobe so the next request overlaps it.
          if ((pend & ~seq_first) == 4'b0000) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_controller.sv
// Directed bench for flag_controller: stimulus queues hand-computed strobe vectors
// tagged with their cycle; a negedge monitor matches every strobe the DUT presents.
module tb_flag_controller;

  logic       clk = 1'b0;
  logic       ExternalReset;
  logic       alu_upd, alu_c, alu_z;
  logic [3:0] flag_op;
  logic       push, pop, sr_c, sr_z;
  logic       SRload, Cin, Zin, Cset, Creset, Zset, Zreset, busy;
  logic [2:0] stack_depth;
  logic       ovf_err, unf_err, drop_err;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic [6:0] v;   // {SRload,Cin,Zin,Cset,Creset,Zset,Zreset}
  } exp_t;
  exp_t q[$];

  localparam logic [6:0] S_CSET   = 7'b000_1000;
  localparam logic [6:0] S_ZSET   = 7'b000_0010;
  localparam logic [6:0] S_ZRESET = 7'b000_0001;

  flag_controller #(.STACK_DEPTH(4)) dut (
    .clk(clk), .ExternalReset(ExternalReset),
    .alu_upd(alu_upd), .alu_c(alu_c), .alu_z(alu_z),
    .flag_op(flag_op), .push(push), .pop(pop), .sr_c(sr_c), .sr_z(sr_z),
    .SRload(SRload), .Cin(Cin), .Zin(Zin),
    .Cset(Cset), .Creset(Creset), .Zset(Zset), .Zreset(Zreset),
    .busy(busy), .stack_depth(stack_depth),
    .ovf_err(ovf_err), .unf_err(unf_err), .drop_err(drop_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] ld(input logic c, input logic z);
    return {1'b1, c, z, 4'b0000};
  endfunction

  task automatic expect_out(input int c, input logic [6:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear();
    alu_upd = 1'b0; alu_c = 1'b0; alu_z = 1'b0;
    flag_op = 4'b0000;
    push = 1'b0; pop = 1'b0; sr_c = 1'b0; sr_z = 1'b0;
  endtask

  // Monitor: any strobe the DUT shows must be the next queued entry for this cycle.
  always @(negedge clk) begin : monitor
    logic [6:0] act;
    exp_t e;
    act = {SRload, Cin, Zin, Cset, Creset, Zset, Zreset};
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_out cyc=%0d: got nothing, required %b", e.cyc, e.v);
    end
    if (act != 7'd0) begin
      checks++;
      if (q.size() == 0 || q[0].cyc != cyc) begin
        failures++;
        $display("FAIL spurious_out cyc=%0d: got %b, required 0000000", cyc, act);
      end else begin
        e = q.pop_front();
        if (act !== e.v) begin
          failures++;
          $display("FAIL strobe cyc=%0d: got %b, required %b", cyc, act, e.v);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [1:0] pv [5];
    logic [1:0] rv [4];
    pv = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b11};
    rv = '{2'b00, 2'b11, 2'b10, 2'b01};
    clear();
    ExternalReset = 1'b1;

    at(1); @(negedge clk);
    chk("rst_outs",  {SRload, Cin, Zin, Cset, Creset, Zset, Zreset, busy}, 0);
    chk("rst_depth", stack_depth, 0);
    chk("rst_errs",  {ovf_err, unf_err, drop_err}, 0);
    at(2); ExternalReset = 1'b0;

    // ALU load
    at(5); alu_upd = 1'b1; alu_c = 1'b1; alu_z = 1'b0; expect_out(6, ld(1'b1, 1'b0));
    at(6); clear(); @(negedge clk); chk("alu_busy", busy, 0);

    // Zset dominates Zreset, so 1011 resolves to Cset then Zset.
    at(10); flag_op = 4'b1011; expect_out(11, S_CSET); expect_out(12, S_ZSET);
    at(11); clear(); @(negedge clk); chk("seq_busy_hi", busy, 1);
    at(12); @(negedge clk); chk("seq_busy_lo", busy, 0);

    at(15); flag_op = 4'b1100; expect_out(16, S_CSET);
    at(16); clear(); @(negedge clk);
    chk("dom_busy", busy, 0);
    chk("dom_errs", {ovf_err, unf_err, drop_err}, 0);

    // New request accepted in the last-strobe cycle
    at(18); flag_op = 4'b1001; expect_out(19, S_CSET); expect_out(20, S_ZRESET);
    at(19); clear();
    at(20); alu_upd = 1'b1; alu_c = 1'b0; alu_z = 1'b1; expect_out(21, ld(1'b0, 1'b1));
    at(21); clear(); @(negedge clk); chk("overlap_drop", drop_err, 0);

    // Fill stack and overflow
    for (int i = 0; i < 5; i++) begin
      at(23 + i); push = 1'b1; {sr_c, sr_z} = pv[i];
    end
    at(28); clear(); @(negedge clk);
    chk("full_depth", stack_depth, 4);
    chk("full_ovf", ovf_err, 1);
    chk("full_unf", unf_err, 0);

    for (int i = 0; i < 4; i++) begin
      at(30 + i); pop = 1'b1; expect_out(31 + i, ld(rv[i][1], rv[i][0]));
    end
    at(34); clear(); @(negedge clk);
    chk("drain_depth", stack_depth, 0);
    chk("drain_unf", unf_err, 0);
    at(35); pop = 1'b1;
    at(36); clear(); @(negedge clk);
    chk("under_unf", unf_err, 1);
    chk("under_depth", stack_depth, 0);

    // Push and pop together
    at(38); push = 1'b1; sr_c = 1'b1; sr_z = 1'b0;
    at(39); push = 1'b1; pop = 1'b1; sr_c = 1'b0; sr_z = 1'b1; expect_out(40, ld(1'b1, 1'b0));
    at(40); clear(); pop = 1'b1; expect_out(41, ld(1'b0, 1'b1));
    @(negedge clk); chk("pp_depth", stack_depth, 1);
    at(41); clear(); @(negedge clk); chk("pp_depth_end", stack_depth, 0);

    // Pop beats alu_upd
    at(43); push = 1'b1; sr_c = 1'b1; sr_z = 1'b1;
    @(negedge clk); chk("pri_drop_pre", drop_err, 0);
    at(44); clear(); pop = 1'b1; alu_upd = 1'b1; expect_out(45, ld(1'b1, 1'b1));
    at(45); clear(); @(negedge clk);
    chk("pri_drop", drop_err, 1);
    chk("pri_depth", stack_depth, 0);

    at(47); ExternalReset = 1'b1;
    at(48); ExternalReset = 1'b0; @(negedge clk);
    chk("rst2_errs", {ovf_err, unf_err, drop_err}, 0);

    // Requests while busy: alu/pop dropped, push served
    at(50); flag_op = 4'b1010; expect_out(51, S_CSET); expect_out(52, S_ZSET);
    at(51); clear(); alu_upd = 1'b1; alu_c = 1'b1; alu_z = 1'b1;
    push = 1'b1; sr_c = 1'b0; sr_z = 1'b1; pop = 1'b1;
    @(negedge clk); chk("busy_hi", busy, 1);
    at(52); clear(); @(negedge clk);
    chk("busy_drop", drop_err, 1);
    chk("busy_push", stack_depth, 1);
    at(53); pop = 1'b1; expect_out(54, ld(1'b0, 1'b1));
    at(54); clear(); @(negedge clk); chk("busy_pop_depth", stack_depth, 0);

    // Reset in the middle of a sequence
    at(55); pop = 1'b1;
    at(56); clear(); flag_op = 4'b1111; push = 1'b1; sr_c = 1'b1; sr_z = 1'b1;
    expect_out(57, S_CSET);
    at(57); clear(); ExternalReset = 1'b1;
    @(negedge clk);
    chk("pre_rst_state", {busy, unf_err, stack_depth}, {1'b1, 1'b1, 3'd1});
    at(58); ExternalReset = 1'b0; @(negedge clk);
    chk("mid_rst_outs", {SRload, Cin, Zin, Cset, Creset, Zset, Zreset, busy}, 0);
    chk("mid_rst_depth", stack_depth, 0);
    chk("mid_rst_errs", {ovf_err, unf_err, drop_err}, 0);

    at(62); @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
